cv32e40x_amo_unit: RTL and testbench
====================================

# cv32e40x_amo_unit

Atomic memory operation sequencer sitting directly downstream of the RV32A decode path, inside the load-store stage. It accepts one decoded atomic request per handshake (LR.W, SC.W, AMO*.W), sequences the required OBI data-bus read and/or write transactions, and computes AMO read-modify-write results. It owns the LR/SC reservation register and returns the value destined for rd, together with an error flag, to writeback.

## Interface
- RSV_ADDR_LSB, default 2: lowest address bit compared for reservation match; the granule is 2^RSV_ADDR_LSB bytes.

- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- req_valid_i  in  1  atomic request valid
- req_ready_o  out  1  request accepted when valid & ready
- req_atop_i  in  6  {1'b1, funct5}; bit5 = 0 is an unsupported request
- req_addr_i  in  32  effective address (rs1)
- req_wdata_i  in  32  rs2 operand
- resp_valid_o  out  1  result valid, held until resp_ready_i
- resp_ready_i  in  1  writeback accepts result
- resp_rdata_o  out  32  value for rd
- resp_err_o  out  1  misaligned, unsupported or bus-error outcome
- mem_req_o  out  1  OBI request
- mem_gnt_i  in  1  OBI grant
- mem_addr_o  out  32  word-aligned address
- mem_we_o  out  1  write enable
- mem_be_o  out  4  always 4'hF when mem_req_o = 1
- mem_wdata_o  out  32  write data
- mem_rvalid_i  in  1  OBI response valid
- mem_rdata_i  in  32  OBI read data
- mem_err_i  in  1  OBI error, qualified by mem_rvalid_i
- rsv_clear_i  in  1  clears the reservation (trap, interrupt, debug entry)
- snoop_we_i  in  1  non-atomic store granted by the regular LSU
- snoop_addr_i  in  32  address of that store

## Operation
- FSM states: IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, RESP.
- req_ready_o = 1 only in IDLE. On acceptance, latch atop, address and wdata.
- Errors detected at acceptance go straight to RESP with resp_err_o = 1, resp_rdata_o = 0, and no bus access:
  - misaligned address (addr[1:0] != 0)
  - req_atop_i[5] = 0
  - funct5 not in {00010 LR, 00011 SC, 00001 SWAP, 00000 ADD, 00100 XOR, 01100 AND, 01000 OR, 10000 MIN, 10100 MAX, 11000 MINU, 11100 MAXU}
- LR: RD_REQ → RD_WAIT → RESP. rdata = mem_rdata_i. On a response without error, set rsv_valid and rsv_addr = addr[31:RSV_ADDR_LSB].
- SC: if rsv_valid and rsv_addr match, go WR_REQ (wdata = rs2) → WR_WAIT → RESP with rdata = 0. Otherwise go straight to RESP with rdata = 1 and no bus access. Every SC clears the reservation at acceptance.
- AMO: RD_REQ → RD_WAIT → WR_REQ → WR_WAIT → RESP. The stored value is new = f(old, rs2). rdata = old.
  - MIN/MAX compare signed 32-bit; MINU/MAXU compare unsigned.
  - ADD wraps modulo 2^32.
- Read-phase error: skip the write, go to RESP with err = 1 and rdata = 0, and clear the reservation.
- Write-phase error: err = 1; rdata as normal (old value for AMO, 0 for SC).
- Reservation clearing:
  - rsv_clear_i
  - snoop_we_i with snoop_addr_i[31:RSV_ADDR_LSB] == rsv_addr
  - any SC
- Clear has priority over a same-cycle LR set: the reservation ends up invalid.

## Timing
- Reset values: all outputs 0; state IDLE; rsv_valid = 0.
- Reset mid-operation abandons the transaction immediately, with no response. Bus-protocol cleanup is the LSU's responsibility.
- mem_req_o, mem_addr_o, mem_we_o and mem_wdata_o are registered and held stable from assertion until the cycle mem_gnt_i = 1. The next state is then the matching WAIT state.
- At most one outstanding bus transaction. mem_rvalid_i outside a WAIT state is ignored.
- Latency with zero-wait grant and rvalid one cycle after grant (accept at edge 0):
  - AMO: resp_valid_o at cycle 5.
  - LR: resp_valid_o at cycle 3.
  - Successful SC: resp_valid_o at cycle 3.
  - Failed SC, misaligned or unsupported: resp_valid_o at cycle 1.
- resp_valid_o, resp_rdata_o and resp_err_o stay stable until resp_ready_i. IDLE is entered on the handshake cycle, and the next request can be accepted the following cycle.

## Test plan
- AMOADD at 0x100, mem = 0x7FFF_FFFF, rs2 = 1 → write 0x8000_0000; rdata = 0x7FFF_FFFF; err = 0.
- AMOMIN vs AMOMINU, old = 0xFFFF_FFFF, rs2 = 1 → stored value 0xFFFF_FFFF (signed) and 1 (unsigned).
- LR.W at 0x200, then SC.W at 0x204 → SC fails: rdata = 1, no mem_req_o.
- LR.W at 0x200, then SC.W at 0x200 → SC succeeds: write issued, rdata = 0.
- Both of the following make a subsequent SC to 0x200 fail:
  - LR at 0x200, then snoop store to 0x200.
  - LR at 0x200 with rsv_clear_i asserted in its rvalid cycle.
- AMOSWAP at 0x102 → err = 1, rdata = 0, no bus access.
- AMOOR with mem_err_i on read → no write, err = 1.
- Grant stalled 3 cycles → address, we and wdata held stable throughout.
- Reset asserted in WR_WAIT → all outputs 0 asynchronously.

Source files
------------

// File: rtl/cv32e40x_amo_unit.sv
// cv32e40x_amo_unit
// Sequences RV32A requests (LR.W, SC.W, AMO*.W) onto the OBI data bus and
// computes read-modify-write results. Owns the LR/SC reservation register.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   req_*               decoded atomic request (valid/ready, atop, addr, rs2)
//   resp_*              result for rd plus error flag (valid/ready)
//   mem_*               OBI master: req/gnt address phase, rvalid response phase
//   rsv_clear_i         external reservation kill (trap, interrupt, debug)
//   snoop_we_i/addr_i   regular LSU store; kills a matching reservation
module cv32e40x_amo_unit #(
    parameter int unsigned RSV_ADDR_LSB = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [5:0]  req_atop_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        resp_valid_o,
    input  logic        resp_ready_i,
    output logic [31:0] resp_rdata_o,
    output logic        resp_err_o,
    output logic        mem_req_o,
    input  logic        mem_gnt_i,
    output logic [31:0] mem_addr_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_err_i,
    input  logic        rsv_clear_i,
    input  logic        snoop_we_i,
    input  logic [31:0] snoop_addr_i
);

    localparam int unsigned TW = 32 - RSV_ADDR_LSB;

    localparam logic [4:0] F_ADD  = 5'b00000, F_SWAP = 5'b00001, F_LR   = 5'b00010,
                           F_SC   = 5'b00011, F_XOR  = 5'b00100, F_OR   = 5'b01000,
                           F_AND  = 5'b01100, F_MIN  = 5'b10000, F_MAX  = 5'b10100,
                           F_MINU = 5'b11000, F_MAXU = 5'b11100;

    typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, RESP} state_e;

    state_e        state_q, state_n;
    logic          up_q;
    logic [4:0]    f5_q, f5_n;
    logic [TW-1:0] tag_q, tag_n;
    logic [31:0]   rs2_q, rs2_n;
    logic          mem_req_q, mem_req_n, mem_we_q, mem_we_n;
    logic [31:0]   mem_addr_q, mem_addr_n, mem_wdata_q, mem_wdata_n;
    logic          resp_valid_q, resp_valid_n, resp_err_q, resp_err_n;
    logic [31:0]   resp_rdata_q, resp_rdata_n;
    logic          rsv_valid_q;
    logic [TW-1:0] rsv_addr_q;
    logic          rsv_set, rsv_drop;

    logic [4:0] req_f5;
    logic       req_bad, req_is_sc, snoop_hit, sc_ok;
    logic       unused_snoop_lsb;

    function automatic logic [31:0] amo_calc(input logic [4:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
        logic lt_s, lt_u;
        lt_s = $signed(a) < $signed(b);
        lt_u = a < b;
        case (op)
            F_ADD:   amo_calc = a + b;
            F_XOR:   amo_calc = a ^ b;
            F_AND:   amo_calc = a & b;
            F_OR:    amo_calc = a | b;
            F_MIN:   amo_calc = lt_s ? a : b;
            F_MAX:   amo_calc = lt_s ? b : a;
            F_MINU:  amo_calc = lt_u ? a : b;
            F_MAXU:  amo_calc = lt_u ? b : a;
            default: amo_calc = b; // SWAP
        endcase
    endfunction

    assign req_f5    = req_atop_i[4:0];
    assign req_is_sc = req_atop_i[5] && (req_f5 == F_SC);
    assign req_bad   = (req_addr_i[1:0] != 2'b00) || !req_atop_i[5] ||
                       !(req_f5 inside {F_LR, F_SC, F_SWAP, F_ADD, F_XOR, F_AND, F_OR,
                                        F_MIN, F_MAX, F_MINU, F_MAXU});
    assign snoop_hit = snoop_we_i && (snoop_addr_i[31:RSV_ADDR_LSB] == rsv_addr_q);
    // A kill arriving in the same cycle as the SC makes it fail.
    assign sc_ok     = rsv_valid_q && (req_addr_i[31:RSV_ADDR_LSB] == rsv_addr_q) &&
                       !rsv_clear_i && !snoop_hit;
    assign unused_snoop_lsb = ^snoop_addr_i[RSV_ADDR_LSB-1:0];

    // up_q keeps req_ready_o low while reset is held so every output is 0.
    assign req_ready_o  = up_q && (state_q == IDLE);
    assign resp_valid_o = resp_valid_q;
    assign resp_rdata_o = resp_rdata_q;
    assign resp_err_o   = resp_err_q;
    assign mem_req_o    = mem_req_q;
    assign mem_we_o     = mem_we_q;
    assign mem_addr_o   = mem_addr_q;
    assign mem_wdata_o  = mem_wdata_q;
    assign mem_be_o     = {4{mem_req_q}};

    always_comb begin
        state_n      = state_q;
        f5_n         = f5_q;
        tag_n        = tag_q;
        rs2_n        = rs2_q;
        mem_req_n    = mem_req_q;
        mem_we_n     = mem_we_q;
        mem_addr_n   = mem_addr_q;
        mem_wdata_n  = mem_wdata_q;
        resp_valid_n = resp_valid_q;
        resp_rdata_n = resp_rdata_q;
        resp_err_n   = resp_err_q;
        rsv_set      = 1'b0;
        rsv_drop     = 1'b0;
        unique case (state_q)
            IDLE: if (req_valid_i && req_ready_o) begin
                f5_n         = req_f5;
                tag_n        = req_addr_i[31:RSV_ADDR_LSB];
                rs2_n        = req_wdata_i;
                mem_addr_n   = {req_addr_i[31:2], 2'b00};
                resp_rdata_n = 32'd0;
                resp_err_n   = 1'b0;
                rsv_drop     = req_is_sc;
                if (req_bad) begin
                    state_n      = RESP;
                    resp_valid_n = 1'b1;
                    resp_err_n   = 1'b1;
                end else if (req_is_sc) begin
                    if (sc_ok) begin
                        state_n     = WR_REQ;
                        mem_req_n   = 1'b1;
                        mem_we_n    = 1'b1;
                        mem_wdata_n = req_wdata_i;
                    end else begin
                        state_n      = RESP;
                        resp_valid_n = 1'b1;
                        resp_rdata_n = 32'd1;
                    end
                end else begin
                    state_n   = RD_REQ;
                    mem_req_n = 1'b1;
                    mem_we_n  = 1'b0;
                end
            end
            RD_REQ: if (mem_gnt_i) begin
                state_n   = RD_WAIT;
                mem_req_n = 1'b0;
            end
            RD_WAIT: if (mem_rvalid_i) begin
                if (mem_err_i) begin
                    state_n      = RESP;
                    resp_valid_n = 1'b1;
                    resp_err_n   = 1'b1;
                    rsv_drop     = 1'b1;
                end else if (f5_q == F_LR) begin
                    state_n      = RESP;
                    resp_valid_n = 1'b1;
                    resp_rdata_n = mem_rdata_i;
                    rsv_set      = 1'b1;
                end else begin
                    state_n      = WR_REQ;
                    mem_req_n    = 1'b1;
                    mem_we_n     = 1'b1;
                    mem_wdata_n  = amo_calc(f5_q, mem_rdata_i, rs2_q);
                    resp_rdata_n = mem_rdata_i;
                end
            end
            WR_REQ: if (mem_gnt_i) begin
                state_n   = WR_WAIT;
                mem_req_n = 1'b0;
                mem_we_n  = 1'b0;
            end
            WR_WAIT: if (mem_rvalid_i) begin
                state_n      = RESP;
                resp_valid_n = 1'b1;
                resp_err_n   = mem_err_i;
            end
            RESP: if (resp_ready_i) begin
                state_n      = IDLE;
                resp_valid_n = 1'b0;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            up_q         <= 1'b0;
            f5_q         <= '0;
            tag_q        <= '0;
            rs2_q        <= '0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_n;
            up_q         <= 1'b1;
            f5_q         <= f5_n;
            tag_q        <= tag_n;
            rs2_q        <= rs2_n;
            mem_req_q    <= mem_req_n;
            mem_we_q     <= mem_we_n;
            mem_addr_q   <= mem_addr_n;
            mem_wdata_q  <= mem_wdata_n;
            resp_valid_q <= resp_valid_n;
            resp_rdata_q <= resp_rdata_n;
            resp_err_q   <= resp_err_n;
        end
    end

    // Any kill wins over an LR setting the reservation in the same cycle,
    // including a snoop that hits the address being reserved.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsv_valid_q <= 1'b0;
            rsv_addr_q  <= '0;
        end else if (rsv_clear_i || rsv_drop || snoop_hit ||
                     (rsv_set && snoop_we_i && (snoop_addr_i[31:RSV_ADDR_LSB] == tag_q))) begin
            rsv_valid_q <= 1'b0;
        end else if (rsv_set) begin
            rsv_valid_q <= 1'b1;
            rsv_addr_q  <= tag_q;
        end
    end

endmodule

// File: tb/tb_cv32e40x_amo_unit.sv
// Scoreboard bench for cv32e40x_amo_unit: a driver computes expected bus
// accesses and responses from a behavioural memory/reservation model, an OBI
// responder and a response monitor compare what the DUT actually does.
module tb_cv32e40x_amo_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        req_valid_i, req_ready_o;
    logic [5:0]  req_atop_i;
    logic [31:0] req_addr_i, req_wdata_i;
    logic        resp_valid_o, resp_ready_i, resp_err_o;
    logic [31:0] resp_rdata_o;
    logic        mem_req_o, mem_gnt_i, mem_we_o, mem_rvalid_i, mem_err_i;
    logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
    logic [3:0]  mem_be_o;
    logic        rsv_clear_i, snoop_we_i;
    logic [31:0] snoop_addr_i;

    always #5 clk = ~clk;

    cv32e40x_amo_unit dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_atop_i(req_atop_i),
        .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
        .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
        .resp_rdata_o(resp_rdata_o), .resp_err_o(resp_err_o),
        .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i), .mem_addr_o(mem_addr_o),
        .mem_we_o(mem_we_o), .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
        .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i), .mem_err_i(mem_err_i),
        .rsv_clear_i(rsv_clear_i), .snoop_we_i(snoop_we_i), .snoop_addr_i(snoop_addr_i)
    );

    localparam logic [4:0] F_ADD  = 5'b00000, F_SWAP = 5'b00001, F_LR   = 5'b00010,
                           F_SC   = 5'b00011, F_XOR  = 5'b00100, F_OR   = 5'b01000,
                           F_AND  = 5'b01100, F_MIN  = 5'b10000, F_MAX  = 5'b10100,
                           F_MINU = 5'b11000, F_MAXU = 5'b11100;

    typedef struct { logic we; logic [31:0] addr; logic [31:0] data; } acc_t;
    typedef struct { logic [31:0] rdata; logic err; } rsp_t;

    acc_t        acc_q[$];
    rsp_t        rsp_q[$];
    logic [31:0] bmem [int];   // memory behind the bus responder
    logic [31:0] mmem [int];   // reference model memory
    logic        rsv_v = 1'b0;
    logic [31:0] rsv_a = '0;   // reserved word index (addr / 4)
    logic [4:0]  amo_ops [9] = '{F_SWAP, F_ADD, F_XOR, F_AND, F_OR, F_MIN, F_MAX, F_MINU, F_MAXU};
    logic [31:0] addrs [4] = '{32'h100, 32'h104, 32'h200, 32'h204};

    int   errors = 0, checks = 0, resp_cnt = 0;
    int   gnt_mode = -1;       // <0: random grant delay 0..3, else fixed
    logic inj_rd_err = 1'b0, inj_wr_err = 1'b0;
    bit   rdy_rand = 1'b1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    function automatic longint sval(input logic [31:0] v);
        return v[31] ? longint'(v) - 64'sd4294967296 : longint'(v);
    endfunction

    function automatic logic [31:0] amo_ref(input logic [4:0] f, input logic [31:0] o,
                                            input logic [31:0] b);
        longint uo, ub, s;
        uo = longint'(o);
        ub = longint'(b);
        case (f)
            F_SWAP:  return b;
            F_ADD:   begin s = (uo + ub) % 64'sd4294967296; return s[31:0]; end
            F_XOR:   return o ^ b;
            F_AND:   return o & b;
            F_OR:    return o | b;
            F_MIN:   return (sval(o) <= sval(b)) ? o : b;
            F_MAX:   return (sval(o) >= sval(b)) ? o : b;
            F_MINU:  return (uo <= ub) ? o : b;
            default: return (uo >= ub) ? o : b;
        endcase
    endfunction

    task automatic setmem(input logic [31:0] a, input logic [31:0] v);
        bmem[int'(a)] = v;
        mmem[int'(a)] = v;
    endtask

    // OBI slave: random or fixed grant delay, rvalid the cycle after grant.
    initial begin
        int          stall;
        bit          active, rv_pend;
        logic        h_we, rv_err;
        logic [31:0] h_addr, h_wdata, rv_data;
        acc_t        e;
        stall = 0; active = 0; rv_pend = 0; rv_err = 0; rv_data = '0;
        h_we = 0; h_addr = '0; h_wdata = '0;
        mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = '0; mem_err_i = 0;
        forever begin
            @(negedge clk);
            mem_gnt_i = 0; mem_rvalid_i = 0; mem_err_i = 0;
            if (!rst_n) begin
                rv_pend = 0; active = 0;
                continue;
            end
            if (rv_pend) begin
                mem_rvalid_i = 1; mem_rdata_i = rv_data; mem_err_i = rv_err; rv_pend = 0;
            end
            if (mem_req_o) begin
                if (!active) begin
                    active = 1; h_we = mem_we_o; h_addr = mem_addr_o; h_wdata = mem_wdata_o;
                    stall = (gnt_mode < 0) ? int'($urandom_range(0, 3)) : gnt_mode;
                end else begin
                    check("hold_we", 64'(mem_we_o), 64'(h_we));
                    check("hold_addr", 64'(mem_addr_o), 64'(h_addr));
                    check("hold_wdata", 64'(mem_wdata_o), 64'(h_wdata));
                end
                if (stall == 0) begin
                    mem_gnt_i = 1; active = 0;
                    check("be", 64'(mem_be_o), 64'hF);
                    if (acc_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_access: we=%0b addr=0x%0h, required no access",
                                 mem_we_o, mem_addr_o);
                    end else begin
                        e = acc_q.pop_front();
                        check("acc_we", 64'(mem_we_o), 64'(e.we));
                        check("acc_addr", 64'(mem_addr_o), 64'(e.addr));
                        if (e.we) check("acc_wdata", 64'(mem_wdata_o), 64'(e.data));
                    end
                    if (mem_we_o) begin
                        rv_err = inj_wr_err;
                        if (!inj_wr_err) bmem[int'(mem_addr_o)] = mem_wdata_o;
                        rv_data = 32'hDEAD_BEEF;
                    end else begin
                        rv_err = inj_rd_err;
                        rv_data = bmem.exists(int'(mem_addr_o)) ? bmem[int'(mem_addr_o)] : 32'h0;
                    end
                    rv_pend = 1;
                end else begin
                    stall--;
                end
            end
        end
    end

    // Response monitor: pops the scoreboard on each handshake, checks holding.
    initial begin
        bit          hold;
        logic [31:0] hd;
        logic        he;
        rsp_t        e;
        hold = 0; hd = '0; he = 0;
        resp_ready_i = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                hold = 0; resp_ready_i = 0;
                continue;
            end
            if (hold) check("resp_hold", {31'd0, resp_valid_o, resp_err_o, resp_rdata_o},
                            {31'd0, 1'b1, he, hd});
            resp_ready_i = rdy_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
            hold = 0;
            if (resp_valid_o) begin
                if (resp_ready_i) begin
                    if (rsp_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_resp: rdata=0x%0h err=%0b, required none",
                                 resp_rdata_o, resp_err_o);
                    end else begin
                        e = rsp_q.pop_front();
                        check("resp_rdata", 64'(resp_rdata_o), 64'(e.rdata));
                        check("resp_err", 64'(resp_err_o), 64'(e.err));
                    end
                    resp_cnt++;
                end else begin
                    hold = 1; hd = resp_rdata_o; he = resp_err_o;
                end
            end
        end
    end

    // Model the request, drive it, then wait for its response.
    task automatic issue(input logic [4:0] f, input logic a5, input logic [31:0] addr,
                         input logic [31:0] rs2, input logic rde, input logic wre,
                         input bit want_resp, input bit clr_rv, output int lat);
        rsp_t r;
        acc_t x;
        logic [31:0] old;
        bit bad;
        int c0, cnt0;
        lat = 0;
        bad = (addr[1:0] != 2'b00) || !a5 ||
              !(f inside {F_LR, F_SC, F_SWAP, F_ADD, F_XOR, F_AND, F_OR, F_MIN, F_MAX, F_MINU, F_MAXU});
        if (bad) begin
            r = '{32'd0, 1'b1};
            if (a5 && f == F_SC) rsv_v = 0;
        end else if (f == F_LR) begin
            x = '{1'b0, addr, 32'd0}; acc_q.push_back(x);
            if (rde) begin r = '{32'd0, 1'b1}; rsv_v = 0; end
            else begin r = '{mmem[int'(addr)], 1'b0}; rsv_v = !clr_rv; rsv_a = addr >> 2; end
        end else if (f == F_SC) begin
            if (rsv_v && rsv_a == (addr >> 2)) begin
                x = '{1'b1, addr, rs2}; acc_q.push_back(x);
                if (!wre) mmem[int'(addr)] = rs2;
                r = '{32'd0, wre};
            end else begin
                r = '{32'd1, 1'b0};
            end
            rsv_v = 0;
        end else begin
            x = '{1'b0, addr, 32'd0}; acc_q.push_back(x);
            if (rde) begin
                r = '{32'd0, 1'b1}; rsv_v = 0;
            end else begin
                old = mmem[int'(addr)];
                x = '{1'b1, addr, amo_ref(f, old, rs2)}; acc_q.push_back(x);
                if (!wre) mmem[int'(addr)] = x.data;
                r = '{old, wre};
            end
        end
        if (want_resp) rsp_q.push_back(r);
        inj_rd_err = rde; inj_wr_err = wre;
        cnt0 = resp_cnt;
        @(negedge clk);
        req_valid_i = 1; req_atop_i = {a5, f}; req_addr_i = addr; req_wdata_i = rs2;
        c0 = 0;
        while (!req_ready_o && c0 < 50) begin @(negedge clk); c0++; end
        if (!req_ready_o) begin
            checks++; errors++;
            $display("FAIL accept_timeout: ready=0 after %0d cycles, required 1", c0);
            req_valid_i = 0;
            return;
        end
        @(posedge clk); #1;
        req_valid_i = 0; req_atop_i = 6'($urandom); req_addr_i = $urandom; req_wdata_i = $urandom;
        if (!want_resp) return;
        if (clr_rv) begin
            c0 = 0;
            do begin @(negedge clk); #1; c0++; end while (!mem_rvalid_i && c0 < 20);
            rsv_clear_i = 1;
            @(negedge clk); rsv_clear_i = 0;
        end else begin
            lat = 1;
            while (!resp_valid_o && lat < 60) begin @(posedge clk); #1; lat++; end
        end
        c0 = 0;
        while (resp_cnt == cnt0 && c0 < 100) begin @(negedge clk); c0++; end
        check("resp_seen", 64'(resp_cnt - cnt0), 64'd1);
        check("bus_ops_left", 64'(acc_q.size()), 64'd0);
    endtask

    task automatic idle_event(input bit clr, input logic [31:0] addr);
        @(negedge clk);
        if (clr) begin
            rsv_clear_i = 1; rsv_v = 0;
        end else begin
            snoop_we_i = 1; snoop_addr_i = addr;
            if (rsv_a == (addr >> 2)) rsv_v = 0;
        end
        @(negedge clk);
        rsv_clear_i = 0; snoop_we_i = 0; snoop_addr_i = $urandom;
    endtask

    initial begin
        int lat, k, c0;
        logic [31:0] a;
        logic [4:0] f;
        logic a5;
        req_valid_i = 0; req_atop_i = '0; req_addr_i = '0; req_wdata_i = '0;
        rsv_clear_i = 0; snoop_we_i = 0; snoop_addr_i = '0;
        for (int i = 0; i < 4; i++) setmem(addrs[i], 32'h1234_0000 + 32'(i));
        #2 rst_n = 0;
        #1;
        check("reset_ctrl", {57'd0, req_ready_o, resp_valid_o, resp_err_o, mem_req_o, mem_we_o,
                             mem_be_o[1:0]}, 64'd0);
        check("reset_be_rdata", {28'd0, mem_be_o, resp_rdata_o}, 64'd0);
        check("reset_addr_wdata", {mem_addr_o, mem_wdata_o}, 64'd0);
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1;
        repeat (2) @(negedge clk);

        // Directed cases with zero-wait grant, always-ready writeback.
        gnt_mode = 0; rdy_rand = 0;
        setmem(32'h100, 32'h7FFF_FFFF);
        issue(F_ADD, 1, 32'h100, 32'd1, 0, 0, 1, 0, lat);
        check("lat_amo", 64'(lat), 64'd5);
        setmem(32'h104, 32'hFFFF_FFFF);
        issue(F_MIN, 1, 32'h104, 32'd1, 0, 0, 1, 0, lat);
        setmem(32'h104, 32'hFFFF_FFFF);
        issue(F_MINU, 1, 32'h104, 32'd1, 0, 0, 1, 0, lat);
        issue(F_LR, 1, 32'h200, 32'd0, 0, 0, 1, 0, lat);
        check("lat_lr", 64'(lat), 64'd3);
        issue(F_SC, 1, 32'h204, 32'h55, 0, 0, 1, 0, lat);
        check("lat_sc_fail", 64'(lat), 64'd1);
        issue(F_LR, 1, 32'h200, 32'd0, 0, 0, 1, 0, lat);
        issue(F_SC, 1, 32'h200, 32'h66, 0, 0, 1, 0, lat);
        check("lat_sc_ok", 64'(lat), 64'd3);
        issue(F_LR, 1, 32'h200, 32'd0, 0, 0, 1, 0, lat);
        idle_event(0, 32'h200);
        issue(F_SC, 1, 32'h200, 32'h77, 0, 0, 1, 0, lat);
        issue(F_LR, 1, 32'h200, 32'd0, 0, 0, 1, 1, lat);
        issue(F_SC, 1, 32'h200, 32'h88, 0, 0, 1, 0, lat);
        issue(F_SWAP, 1, 32'h102, 32'h99, 0, 0, 1, 0, lat);
        check("lat_misaligned", 64'(lat), 64'd1);
        issue(F_ADD, 0, 32'h100, 32'h1, 0, 0, 1, 0, lat);
        issue(5'b00101, 1, 32'h100, 32'h1, 0, 0, 1, 0, lat);
        issue(F_OR, 1, 32'h104, 32'hF0, 1, 0, 1, 0, lat);
        issue(F_XOR, 1, 32'h104, 32'hF0, 0, 1, 1, 0, lat);
        gnt_mode = 3;
        issue(F_XOR, 1, 32'h204, 32'hA5A5_5A5A, 0, 0, 1, 0, lat);

        // Randomized traffic.
        gnt_mode = -1; rdy_rand = 1;
        for (int n = 0; n < 300; n++) begin
            k = int'($urandom_range(0, 99));
            a = addrs[$urandom_range(0, 3)];
            a5 = 1;
            f = amo_ops[$urandom_range(0, 8)];
            if (k < 5) a5 = 0;
            else if (k < 10) f = ($urandom_range(0, 1) != 0) ? 5'b00101 : 5'b11111;
            else if (k < 15) a = a | 32'($urandom_range(1, 3));
            else if (k < 30) f = F_LR;
            else if (k < 50) f = F_SC;
            issue(f, a5, a, $urandom, ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0),
                  1, 0, lat);
            if ($urandom_range(0, 9) < 2)
                idle_event($urandom_range(0, 3) == 0, addrs[$urandom_range(0, 3)] | 32'($urandom_range(0, 3)));
        end

        // Reset while waiting for the write response: no response, outputs 0.
        gnt_mode = 0; rdy_rand = 0;
        issue(F_ADD, 1, 32'h100, 32'h3, 0, 0, 0, 0, lat);
        c0 = 0;
        while (!(mem_req_o && mem_we_o) && c0 < 20) begin @(negedge clk); c0++; end
        check("wr_phase_reached", 64'(mem_req_o && mem_we_o), 64'd1);
        @(posedge clk); #2;
        rst_n = 0;
        #1;
        check("rst_mid_ctrl", {57'd0, req_ready_o, resp_valid_o, resp_err_o, mem_req_o, mem_we_o,
                               mem_be_o[1:0]}, 64'd0);
        check("rst_mid_rdata_be", {28'd0, mem_be_o, resp_rdata_o}, 64'd0);
        check("rst_mid_addr_wdata", {mem_addr_o, mem_wdata_o}, 64'd0);
        check("rst_mid_bus_ops_left", 64'(acc_q.size()), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1;
        repeat (3) @(negedge clk);
        check("no_resp_after_reset", 64'(rsp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
